// File: rtl/ultrasonic_array_ctrl_if.sv
// Control/status bundle between mobility logic
// and the ultrasonic ranger array controller.
interface ultrasonic_array_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int DIST_W = 16
);
  logic                     start;
  logic                     mode;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        sensor_echo;
  logic [NUM_CH-1:0]        sensor_trig;
  logic [NUM_CH*DIST_W-1:0] distance;
  logic [NUM_CH-1:0]        valid;
  logic [NUM_CH-1:0]        err;
  logic                     busy;
  logic [2:0]               cur_ch;
  logic                     sweep_done;

  modport master (
    output start, mode, ch_en, sensor_echo,
    input  sensor_trig, distance, valid, err,
    input  busy, cur_ch, sweep_done
  );

  modport slave (
    input  start, mode, ch_en, sensor_echo,
    output sensor_trig, distance, valid, err,
    output busy, cur_ch, sweep_done
  );
endinterface

// File: rtl/ultrasonic_array_ctrl.sv
// Round-robin HC-SR04 array sequencer: one ping
// at a time, echo timed through a prescaler.
module ultrasonic_array_ctrl #(
  parameter int NUM_CH           = 4,
  parameter int DIST_W           = 16,
  parameter int CNT_W            = 22,
  parameter int TRIG_CYCLES      = 500,
  parameter int ECHO_WAIT_CYCLES = 925000,
  parameter int ECHO_MAX_CYCLES  = 1900000,
  parameter int HOLDOFF_CYCLES   = 3000000,
  parameter int DIV              = 2900
) (
  input logic                    clk50,
  input logic                    rst,
  ultrasonic_array_ctrl_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] T_TRIG =
    CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_WAIT =
    CNT_W'(ECHO_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_MAX =
    CNT_W'(ECHO_MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_HOLD =
    CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST =
    PW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    STORE,
    ERRW,
    HOLDOFF
  } state_t;

  state_t                   state;
  logic [NUM_CH-1:0]        echo_m;
  logic [NUM_CH-1:0]        echo_s;
  logic [CNT_W-1:0]         timer;
  logic [PW-1:0]            presc;
  logic [DIST_W-1:0]        dcnt;
  logic [3:0]               ptr;
  logic [2:0]               ch;
  logic [NUM_CH-1:0]        trig;
  logic [NUM_CH-1:0]        valid_r;
  logic [NUM_CH-1:0]        err_r;
  logic [NUM_CH*DIST_W-1:0] dist_r;
  logic                     done_r;
  logic                     echo;
  logic                     found;
  logic [2:0]               sel;

  // Two-flop synchroniser on every raw echo line.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      echo_m <= '0;
      echo_s <= '0;
    end else begin
      echo_m <= bus.sensor_echo;
      echo_s <= echo_m;
    end
  end

  // Synchronised echo of the channel in service.
  always_comb begin
    echo = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch == 3'(i))
        echo = echo_s[i];
  end

  // Lowest enabled channel at or above the pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (bus.ch_en[i] && (4'(i) >= ptr)) begin
        found = 1'b1;
        sel   = 3'(i);
      end
  end

  // Sequencer, echo timing and result registers.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      presc   <= '0;
      dcnt    <= '0;
      ptr     <= '0;
      ch      <= '0;
      trig    <= '0;
      valid_r <= '0;
      err_r   <= '0;
      dist_r  <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (|bus.ch_en) begin
              ptr   <= '0;
              state <= SELECT;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        SELECT: begin
          if (found) begin
            ch    <= sel;
            timer <= '0;
            for (int i = 0; i < NUM_CH; i++)
              trig[i] <= (sel == 3'(i));
            state <= TRIG;
          end else begin
            done_r <= 1'b1;
            ptr    <= '0;
            state  <= bus.mode ? SELECT : IDLE;
          end
        end
        TRIG: begin
          if (timer == T_TRIG) begin
            trig  <= '0;
            timer <= '0;
            state <= WAIT_ECHO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_ECHO: begin
          if (echo) begin
            timer <= '0;
            presc <= '0;
            dcnt  <= '0;
            state <= MEASURE;
          end else if (timer == T_WAIT) begin
            state <= ERRW;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        MEASURE: begin
          if (presc == P_LAST) begin
            presc <= '0;
            if (dcnt != '1)
              dcnt <= dcnt + 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
          if (!echo)
            state <= STORE;
          else if (timer == T_MAX)
            state <= ERRW;
          else
            timer <= timer + 1'b1;
        end
        STORE: begin
          for (int i = 0; i < NUM_CH; i++)
            if (ch == 3'(i)) begin
              dist_r[i*DIST_W +: DIST_W] <= dcnt;
              valid_r[i] <= 1'b1;
              err_r[i]   <= 1'b0;
            end
          timer <= '0;
          state <= HOLDOFF;
        end
        ERRW: begin
          for (int i = 0; i < NUM_CH; i++)
            if (ch == 3'(i)) begin
              valid_r[i] <= 1'b0;
              err_r[i]   <= 1'b1;
            end
          timer <= '0;
          state <= HOLDOFF;
        end
        HOLDOFF: begin
          if (timer == T_HOLD) begin
            ptr   <= {1'b0, ch} + 4'd1;
            state <= SELECT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sensor_trig = trig;
  assign bus.distance    = dist_r;
  assign bus.valid       = valid_r;
  assign bus.err         = err_r;
  assign bus.busy        = (state != IDLE);
  assign bus.cur_ch      = ch;
  assign bus.sweep_done  = done_r;

endmodule

// File: tb/tb_ultrasonic_array_ctrl.sv
// Bench for the ultrasonic array controller:
// echo-driving sensor models plus a result model.
module tb_ultrasonic_array_ctrl;

  logic       clk50;
  logic       rst;
  wire  [3:0] echo_w;

  ultrasonic_array_ctrl_if #(
    .NUM_CH(4), .DIST_W(4)
  ) u_if ();

  ultrasonic_array_ctrl #(
    .NUM_CH(4),
    .DIST_W(4),
    .CNT_W(22),
    .TRIG_CYCLES(10),
    .ECHO_WAIT_CYCLES(100),
    .ECHO_MAX_CYCLES(400),
    .HOLDOFF_CYCLES(20),
    .DIV(10)
  ) u_dut (
    .clk50(clk50),
    .rst(rst),
    .bus(u_if.slave)
  );

  assign u_if.sensor_echo = echo_w;

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  int checks   = 0;
  int failures = 0;

  // echo plan per channel: delay after trigger
  // fall (-1 = never) and high time in clocks
  int pd[4];
  int pn[4];

  // behavioural result model
  int m_dist[4];
  bit m_val[4];
  bit m_err[4];
  int due[4];
  int p_dist[4];
  bit p_ok[4];

  int exp_q[$];
  int ntrig  = 0;
  int nsweep = 0;
  int cyc    = 0;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d",
               name, act, exp);
    end
  endtask

  // sensor models, one per channel
  for (genvar g = 0; g < 4; g++) begin : g_sens
    logic e;
    assign echo_w[g] = e;
    initial begin
      e = 1'b0;
      forever begin
        @(posedge u_if.sensor_trig[g]);
        @(negedge u_if.sensor_trig[g]);
        if (!rst && pd[g] >= 0) begin
          repeat (pd[g]) @(posedge clk50);
          #1 e = 1'b1;
          repeat (pn[g]) @(posedge clk50);
          #1 e = 1'b0;
        end
      end
    end
  end

  // per-cycle comparison against the model
  logic [3:0]  prev = '0;
  int          hi = 0;
  int          act_ch = 0;
  int          last_v = -1;
  int          last_ch = 0;
  logic [15:0] ed;
  logic [3:0]  ev;
  logic [3:0]  ee;

  always @(negedge clk50) begin : cmp
    int ch_now;
    if (rst) begin
      chk("reset_state",
          {u_if.sensor_trig, u_if.valid, u_if.err,
           u_if.distance, u_if.busy,
           u_if.sweep_done, u_if.cur_ch}, 0);
      for (int c = 0; c < 4; c++) begin
        m_dist[c] = 0;
        m_val[c]  = 1'b0;
        m_err[c]  = 1'b0;
        due[c]    = -1;
      end
      exp_q.delete();
      hi     = 0;
      last_v = -1;
    end else begin
      cyc++;
      for (int c = 0; c < 4; c++)
        if (due[c] == cyc) begin
          if (p_ok[c]) begin
            m_dist[c] = p_dist[c];
            m_val[c]  = 1'b1;
            m_err[c]  = 1'b0;
          end else begin
            m_val[c]  = 1'b0;
            m_err[c]  = 1'b1;
          end
          due[c]  = -1;
          last_v  = cyc;
          last_ch = c;
        end
      for (int c = 0; c < 4; c++) begin
        ed[c*4 +: 4] = 4'(m_dist[c]);
        ev[c] = m_val[c];
        ee[c] = m_err[c];
      end
      chk("distance", u_if.distance, ed);
      chk("valid", u_if.valid, ev);
      chk("err", u_if.err, ee);
      ch_now = 0;
      for (int c = 0; c < 4; c++)
        if (u_if.sensor_trig[c]) ch_now = c;
      if (u_if.sensor_trig != 0) begin
        chk("trig_onehot",
            $countones(u_if.sensor_trig), 1);
        chk("trig_cur_ch", u_if.cur_ch, ch_now);
      end
      if (u_if.sensor_trig != 0 && prev == 0) begin
        ntrig++;
        hi     = 1;
        act_ch = ch_now;
        chk("trig_expected",
            int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0)
          chk("trig_order", ch_now, exp_q.pop_front());
        if (last_v >= 0)
          chk("holdoff_gap", cyc - last_v,
              (ch_now > last_ch) ? 21 : 22);
      end else if (u_if.sensor_trig != 0) begin
        hi++;
      end else if (prev != 0) begin
        chk("trig_width", hi, 10);
        p_ok[act_ch] = 1'b0;
        if (pd[act_ch] < 0 || pd[act_ch] > 97) begin
          due[act_ch] = cyc + 101;
        end else if (pn[act_ch] > 400) begin
          due[act_ch] = cyc + pd[act_ch] + 404;
        end else begin
          due[act_ch] = cyc + pd[act_ch]
                        + pn[act_ch] + 4;
          p_ok[act_ch]   = 1'b1;
          p_dist[act_ch] = (pn[act_ch] / 10 > 15)
                           ? 15 : pn[act_ch] / 10;
        end
      end
      if (u_if.sweep_done) nsweep++;
      if (!u_if.busy) last_v = -1;
    end
    prev = u_if.sensor_trig;
  end

  task automatic pulse_start();
    @(posedge clk50);
    #1 u_if.start = 1'b1;
    @(posedge clk50);
    #1 u_if.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(posedge clk50);
      #2;
      if (!u_if.busy) break;
      k++;
    end
    chk("idle_reached", int'(k < budget), 1);
    repeat (60) @(posedge clk50);
    #2;
  endtask

  task automatic wait_trig(input int n,
                           input int budget);
    int k;
    k = 0;
    while (k < budget && ntrig < n) begin
      @(posedge clk50);
      #2;
      k++;
    end
    chk("trig_reached", int'(ntrig >= n), 1);
  endtask

  task automatic push_en(input logic [3:0] en);
    for (int c = 0; c < 4; c++)
      if (en[c]) exp_q.push_back(c);
  endtask

  initial begin
    int s0;
    int n0;
    logic [3:0] en;
    rst          = 1'b1;
    u_if.start   = 1'b0;
    u_if.mode    = 1'b0;
    u_if.ch_en   = '0;
    for (int c = 0; c < 4; c++) begin
      pd[c]  = -1;
      pn[c]  = 1;
      due[c] = -1;
    end
    repeat (3) @(posedge clk50);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk50);

    // single sweep, all channels
    pd = '{5, 5, 5, 5};
    pn = '{57, 123, 10, 9};
    u_if.ch_en = 4'hF;
    u_if.mode  = 1'b0;
    push_en(4'hF);
    s0 = nsweep;
    n0 = ntrig;
    pulse_start();
    chk("busy_after_start", u_if.busy, 1);
    wait_trig(n0 + 2, 2000);
    pulse_start();
    wait_idle(20000);
    chk("t1_distance", u_if.distance, 16'h01C5);
    chk("t1_valid", u_if.valid, 4'hF);
    chk("t1_err", u_if.err, 4'h0);
    chk("t1_sweeps", nsweep - s0, 1);
    chk("t1_triggers", ntrig - n0, 4);
    chk("t1_busy", u_if.busy, 0);

    // wait-for-echo boundaries and stuck echo
    pd = '{97, 98, -1, 5};
    pn = '{30, 5, 1, 70};
    push_en(4'hF);
    pulse_start();
    wait_idle(20000);
    chk("t2_distance", u_if.distance, 16'h71C3);
    chk("t2_valid", u_if.valid, 4'b1001);
    chk("t2_err", u_if.err, 4'b0110);

    // saturation and overlong echo
    pd = '{3, 2, 0, 0};
    pn = '{200, 500, 400, 401};
    push_en(4'hF);
    pulse_start();
    wait_idle(20000);
    chk("t3_distance", u_if.distance, 16'h7FCF);
    chk("t3_valid", u_if.valid, 4'b0101);
    chk("t3_err", u_if.err, 4'b1010);

    // masked continuous scan, then stop
    pd[1] = $urandom_range(0, 97);
    pd[3] = $urandom_range(0, 97);
    pn[1] = $urandom_range(1, 300);
    pn[3] = $urandom_range(1, 300);
    u_if.ch_en = 4'b1010;
    u_if.mode  = 1'b1;
    for (int r = 0; r < 3; r++) push_en(4'b1010);
    s0 = nsweep;
    n0 = ntrig;
    pulse_start();
    wait_trig(n0 + 5, 8000);
    u_if.mode = 1'b0;
    wait_idle(20000);
    chk("t4_sweeps", nsweep - s0, 3);
    chk("t4_triggers", ntrig - n0, 6);
    chk("t4_queue", exp_q.size(), 0);

    // empty mask
    u_if.ch_en = 4'h0;
    s0 = nsweep;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk50);
      #2 chk("t5_busy", u_if.busy, 0);
    end
    chk("t5_sweeps", nsweep - s0, 1);

    // randomized single sweeps
    for (int it = 0; it < 6; it++) begin
      int r;
      en = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) begin
        r = $urandom_range(0, 9);
        pd[c] = (r == 0) ? -1 : $urandom_range(0, 97);
        pn[c] = $urandom_range(1,
                  (r == 1) ? 450 : 250);
      end
      u_if.ch_en = en;
      push_en(en);
      s0 = nsweep;
      n0 = ntrig;
      pulse_start();
      wait_idle(20000);
      chk("rnd_sweeps", nsweep - s0, 1);
      chk("rnd_triggers", ntrig - n0,
          $countones(en));
    end

    // reset in the middle of a trigger pulse
    pd = '{5, 5, 5, 5};
    pn = '{20, 20, 20, 20};
    u_if.ch_en = 4'hF;
    push_en(4'hF);
    n0 = ntrig;
    pulse_start();
    wait_trig(n0 + 1, 200);
    repeat (4) @(posedge clk50);
    #1 rst = 1'b1;
    #1;
    chk("rst_trig", u_if.sensor_trig, 0);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_valid", u_if.valid, 0);
    chk("rst_err", u_if.err, 0);
    chk("rst_distance", u_if.distance, 0);
    chk("rst_cur_ch", u_if.cur_ch, 0);
    repeat (3) @(posedge clk50);
    #1 rst = 1'b0;
    repeat (80) @(posedge clk50);
    pd = '{5, 5, 5, 5};
    pn = '{33, 20, 88, 20};
    u_if.ch_en = 4'b0101;
    push_en(4'b0101);
    pulse_start();
    wait_idle(20000);
    chk("t7_distance", u_if.distance, 16'h0803);
    chk("t7_valid", u_if.valid, 4'b0101);
    chk("t7_err", u_if.err, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
